// File: rtl/rc_add_sub_32_reg.sv
// Full-adder cell used as one link of the ripple chain.
// Purely combinational; no state.
module rc_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// Ripple-carry adder/subtractor (sna: 0 = a+b, 1 = a-b) with registered y/cout/v.
// Latency: 1 cycle from operands to registered result.
// Backpressure: none; new operands are accepted every cycle, no handshake.
module rc_add_sub_32_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sna,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             v
);
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    // Subtraction as a + ~b + 1: invert b and inject the +1 as carry-in.
    assign c[0] = sna;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        assign bi[i] = b[i] ^ sna;

        rc_fa u_fa (
            .a  (a[i]),
            .b  (bi[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Output register cuts the ripple path off from downstream logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            cout <= 1'b0;
            v    <= 1'b0;
        end else begin
            y    <= s;
            cout <= c[WIDTH];
            v    <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_rc_add_sub_32_reg.sv
// Bench for rc_add_sub_32_reg: arithmetic model checked every cycle, plus literal vectors.
module tb_rc_add_sub_32_reg;
    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        sna;
    logic [31:0] y;
    logic        cout;
    logic        v;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_y;
    logic        m_c;
    logic        m_v;

    rc_add_sub_32_reg #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sna   (sna),
        .y     (y),
        .cout  (cout),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: plain integer arithmetic on the operands sampled at the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y <= '0;
            m_c <= 1'b0;
            m_v <= 1'b0;
        end else begin
            logic [32:0] wide;
            longint      sa, sb, sr;
            wide = {1'b0, a} + {1'b0, (b ^ {32{sna}})} + 33'(sna);
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            sr   = sna ? (sa - sb) : (sa + sb);
            m_y <= wide[31:0];
            m_c <= wide[32];
            m_v <= (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
    end

    // Compare process: every cycle, 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        checks++;
        if ({y, cout, v} !== {m_y, m_c, m_v}) begin
            errors++;
            $display("FAIL model t=%0t: got y=%08h cout=%b v=%b, want y=%08h cout=%b v=%b",
                     $time, y, cout, v, m_y, m_c, m_v);
        end
    end

    task automatic check_lit(input string name, input logic [31:0] ey, input logic ec, input logic ev);
        checks++;
        if ({y, cout, v} !== {ey, ec, ev}) begin
            errors++;
            $display("FAIL %s: got y=%08h cout=%b v=%b, want y=%08h cout=%b v=%b",
                     name, y, cout, v, ey, ec, ev);
        end
    endtask

    // Apply operands at the falling edge, then look at the result after the next rising edge.
    task automatic run_lit(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic ts, input logic [31:0] ey, input logic ec, input logic ev);
        @(negedge clk);
        a = ta; b = tb_; sna = ts;
        @(posedge clk);
        #2;
        check_lit(name, ey, ec, ev);
    endtask

    initial begin
        rst_n = 1'b1;
        a = 32'hDEADBEEF; b = 32'h12345678; sna = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_lit("reset_async", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_lit("reset_hold", 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_lit("add_carry",  32'hFFFFFFFF, 32'h80000001, 1'b0, 32'h80000000, 1'b1, 1'b0);
        run_lit("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_lit("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_lit("sub_5_3",    32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0);
        run_lit("sub_0_0",    32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        run_lit("sub_borrow", 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_lit("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_lit("add_plain",  32'h00001234, 32'h00004321, 1'b0, 32'h00005555, 1'b0, 1'b0);

        // Back-to-back with sna toggling each cycle; the model checks every result.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a   = 32'h1000_0000 * i + 32'h0F0F_0F0F;
            b   = 32'hF000_0001 - 32'h0111_1111 * i;
            sna = i[0];
        end

        // Mid-operation reset between edges: outputs must clear at once.
        @(negedge clk);
        a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; sna = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 32'h00000009; b = 32'h00000004; sna = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_lit("reset_midop", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2 check_lit("reset_discard", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_lit("after_reset", 32'h00000009, 32'h00000004, 1'b1, 32'h00000005, 1'b1, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a   = $urandom;
            b   = $urandom;
            sna = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
